// File: rtl/spi_config_loader.sv
// Assembles SPI bytes into a 32-bit configuration word and commits it to the live register only at vertical-sync start.
// Optional build macro SPI_CFG_CHECKSUM_EN adds a fifth XOR checksum byte to every frame.
module spi_config_loader #(
    parameter logic [31:0] RESET_CONFIG  = 32'hBBFC0000,
    parameter bit          VS_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        ss,
    input  logic        vs,
    output logic [31:0] config_out,
    output logic        config_updated,
    output logic        frame_error,
    output logic        pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PENDING = 2'd2
    } state_t;

`ifdef SPI_CFG_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    state_t      state;
    state_t      next_state;
    logic        ss_q;
    logic        vs_q;
    logic [2:0]  count;
    logic [31:0] shadow;

    logic ss_fall;
    logic ss_rise;
    logic vs_start;
    logic word_done;
    logic checksum_ok;
    logic shift_en;
    logic count_clr;
    logic count_inc;
    logic commit;
    logic frame_err_set;

    assign ss_fall   = ss_q & ~ss;
    assign ss_rise   = ~ss_q & ss;
    assign vs_start  = VS_ACTIVE_LOW ? (vs_q & ~vs) : (~vs_q & vs);
    assign word_done = (state == COLLECT) && byte_valid && (count == LAST_IDX);

`ifdef SPI_CFG_CHECKSUM_EN
    assign checksum_ok = ((shadow[31:24] ^ shadow[23:16] ^ shadow[15:8] ^ shadow[7:0]) == byte_in);
`else
    assign checksum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ss_fall) next_state = COLLECT;
            end
            COLLECT: begin
                if (word_done) begin
                    next_state = checksum_ok ? PENDING : IDLE;
                end else if (ss_rise) begin
                    next_state = IDLE;
                end
            end
            PENDING: begin
                if (vs_start) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // A frame ending on the same edge as its final byte counts as complete, not short.
    always_comb begin
        pending       = (state == PENDING);
        commit        = (state == PENDING) && vs_start;
        count_clr     = (state == IDLE) && ss_fall;
        count_inc     = (state == COLLECT) && byte_valid && !word_done;
        shift_en      = (state == COLLECT) && byte_valid && (count < 3'd4);
        frame_err_set = (state == COLLECT) &&
                        ((ss_rise && !word_done) || (word_done && !checksum_ok));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q           <= 1'b1;
            vs_q           <= 1'b1;
            count          <= 3'd0;
            shadow         <= 32'd0;
            config_out     <= RESET_CONFIG;
            config_updated <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            ss_q           <= ss;
            vs_q           <= vs;
            config_updated <= commit;
            frame_error    <= frame_err_set;
            if (count_clr) begin
                count <= 3'd0;
            end else if (count_inc) begin
                count <= count + 3'd1;
            end
            if (frame_err_set) begin
                shadow <= 32'd0;
            end else if (shift_en) begin
                shadow <= {shadow[23:0], byte_in};
            end
            if (commit) begin
                config_out <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_spi_config_loader.sv
// Scoreboard bench for spi_config_loader: stimulus pushes expected commit/error events, a monitor pops and compares them.
module tb_spi_config_loader;

    localparam logic [31:0] RESET_CFG = 32'hBBFC0000;

    typedef logic [7:0] byteQ_t[$];
    typedef struct {
        bit          isErr;
        logic [31:0] cfg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        ss;
    logic        vs;
    logic [31:0] config_out;
    logic        config_updated;
    logic        frame_error;
    logic        pending;

    exp_t        expQ[$];
    logic [31:0] expCfg;
    int          total;
    int          bad;

    spi_config_loader #(
        .RESET_CONFIG (RESET_CFG),
        .VS_ACTIVE_LOW(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .ss            (ss),
        .vs            (vs),
        .config_out    (config_out),
        .config_updated(config_updated),
        .frame_error   (frame_error),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic expPend, input logic [31:0] expC);
        @(negedge clk);
        checkOutput({tag, " pending"}, {31'd0, pending}, {31'd0, expPend});
        checkOutput({tag, " config_out"}, config_out, expC);
    endtask

    task automatic pushExp(input bit isErr, input logic [31:0] cfg);
        exp_t e;
        e.isErr = isErr;
        e.cfg   = cfg;
        expQ.push_back(e);
    endtask

    function automatic byteQ_t mkFrame(input logic [31:0] w);
        byteQ_t q;
        q = {w[31:24], w[23:16], w[15:8], w[7:0]};
`ifdef SPI_CFG_CHECKSUM_EN
        q.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
        return q;
    endfunction

    task automatic sendByte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        tick();
    endtask

    // Select, send the bytes, deselect; riseWithLast lifts ss on the final byte's cycle.
    task automatic applyStimulus(input byteQ_t bytes, input bit riseWithLast);
        ss = 1'b0;
        tick();
        for (int i = 0; i < bytes.size(); i++) begin
            byte_in    = bytes[i];
            byte_valid = 1'b1;
            if (riseWithLast && (i == bytes.size() - 1)) ss = 1'b1;
            tick();
            byte_valid = 1'b0;
            tick();
        end
        ss = 1'b1;
        repeat (2) tick();
    endtask

    task automatic vsPulse();
        vs = 1'b0;
        repeat (3) tick();
        vs = 1'b1;
        repeat (2) tick();
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && (config_updated || frame_error)) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected event: updated=%0b error=%0b config_out=%h expected no event",
                             config_updated, frame_error, config_out);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("event is frame_error", {31'd0, frame_error}, {31'd0, e.isErr});
                    checkOutput("event updated flag", {31'd0, config_updated}, {31'd0, !e.isErr});
                    checkOutput("config_out at event", config_out, e.cfg);
                end
            end
        end
    end

    initial begin : stimulus
        byteQ_t q;
        logic [7:0] lastByte;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        ss         = 1'b1;
        vs         = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        expCfg     = RESET_CFG;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        @(negedge clk);
        checkOutput("reset config_out", config_out, RESET_CFG);
        checkOutput("reset config_updated", {31'd0, config_updated}, 32'd0);
        checkOutput("reset frame_error", {31'd0, frame_error}, 32'd0);
        checkOutput("reset pending", {31'd0, pending}, 32'd0);

        // Normal write waits for vs_start
        applyStimulus(mkFrame(32'h403F0000), 1'b0);
        checkState("normal before vs", 1'b1, expCfg);
        pushExp(1'b0, 32'h403F0000);
        expCfg = 32'h403F0000;
        vsPulse();
        checkState("normal after vs", 1'b0, expCfg);

        // Short frame discarded
        pushExp(1'b1, expCfg);
        q = {8'h12, 8'h34};
        applyStimulus(q, 1'b0);
        checkState("short frame", 1'b0, expCfg);
        vsPulse();
        checkState("short after vs", 1'b0, expCfg);

        // ss rises on the completing byte
        applyStimulus(mkFrame(32'hC0000001), 1'b1);
        checkState("rise with last", 1'b1, expCfg);
        pushExp(1'b0, 32'hC0000001);
        expCfg = 32'hC0000001;
        vsPulse();
        checkState("rise with last after vs", 1'b0, expCfg);

        // Completing byte coincides with vs_start, then an overrun byte
        q = mkFrame(32'hAABBCCDD);
        lastByte = q.pop_back();
        ss = 1'b0;
        tick();
        for (int i = 0; i < q.size(); i++) sendByte(q[i]);
        byte_in    = lastByte;
        byte_valid = 1'b1;
        vs         = 1'b0;
        tick();
        byte_valid = 1'b0;
        tick();
        checkState("coincident vs no commit", 1'b1, expCfg);
        sendByte(8'hEE);
        vs = 1'b1;
        ss = 1'b1;
        repeat (3) tick();
        checkState("overrun still pending", 1'b1, expCfg);
        pushExp(1'b0, 32'hAABBCCDD);
        expCfg = 32'hAABBCCDD;
        vsPulse();
        checkState("overrun after vs", 1'b0, expCfg);

`ifdef SPI_CFG_CHECKSUM_EN
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        applyStimulus(q, 1'b0);
        checkState("checksum good", 1'b1, expCfg);
        pushExp(1'b0, 32'h01020304);
        expCfg = 32'h01020304;
        vsPulse();
        checkState("checksum good after vs", 1'b0, expCfg);

        pushExp(1'b1, expCfg);
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        applyStimulus(q, 1'b0);
        checkState("checksum bad", 1'b0, expCfg);
        vsPulse();
        checkState("checksum bad after vs", 1'b0, expCfg);
`endif

        // Reset while a word is pending loses it
        applyStimulus(mkFrame(32'h11223344), 1'b0);
        checkState("pending before reset", 1'b1, expCfg);
        rst_n = 1'b0;
        #2;
        checkOutput("async reset config_out", config_out, RESET_CFG);
        checkOutput("async reset pending", {31'd0, pending}, 32'd0);
        tick();
        rst_n  = 1'b1;
        expCfg = RESET_CFG;
        tick();
        vsPulse();
        checkState("after reset vs", 1'b0, expCfg);

        repeat (5) tick();
        checkOutput("scoreboard drained", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_config_loader.md
Name: spi_config_loader

Overview:
- Sits between the SPI peripheral's received-byte output and the 32-bit configuration register that drives pixel_mux select and colour.
- Assembles SPI bytes into a full 32-bit configuration word, MSB byte first, into a shadow register.
- Commits the word to the live configuration only at the start of vertical sync, so the picture never tears mid-frame.
- Rejects short frames.

Parameters:
- RESET_CONFIG, 32'hBBFC0000: value of config_out after reset.
- VS_ACTIVE_LOW, 1: 1 = vs is asserted low; 0 = vs is asserted high.

Ports:
- clk  input  1  system/pixel clock
- rst_n  input  1  asynchronous active-low reset
- byte_in  input  8  byte from SPI peripheral
- byte_valid  input  1  one-cycle strobe; byte_in is valid this cycle
- ss  input  1  SPI chip select, active low, already synchronised to clk
- vs  input  1  vertical sync from the VGA timing generator
- config_out  output  32  live configuration word
- config_updated  output  1  one-cycle pulse on the cycle config_out changes
- frame_error  output  1  one-cycle pulse when a frame is discarded
- pending  output  1  high while a complete word waits for commit

Behaviour:
- Reset (async, rst_n low):
  - config_out = RESET_CONFIG; shadow = 0; byte count = 0; state = IDLE.
  - config_updated, frame_error and pending all 0.
- Edge detection:
  - ss_q and vs_q are registered copies of ss and vs; both reset to 1 (the deasserted level when VS_ACTIVE_LOW = 1).
  - ss_fall = ss_q & ~ss.
  - ss_rise = ~ss_q & ss.
  - vs_start = transition of vs into its asserted level.
- States: IDLE, COLLECT, PENDING.
- IDLE:
  - ss_fall -> COLLECT, count = 0.
  - byte_valid is ignored.
- COLLECT:
  - Each byte_valid: shadow = {shadow[23:0], byte_in}, count = count + 1.
  - When the 4th byte is accepted -> PENDING next cycle.
  - ss_rise with count < 4 and no byte_valid completing the word: discard the frame, pulse frame_error next cycle, -> IDLE. config_out is unchanged.
  - ss_rise and the 4th byte_valid in the same cycle: the byte is accepted and the frame is complete -> PENDING; no error.
  - ss_fall while already in COLLECT: not possible without an intervening rise; no special handling.
- PENDING:
  - pending = 1.
  - Further byte_valid is ignored (overrun bytes dropped; no error).
  - On vs_start: config_out = shadow, config_updated = 1 for exactly that cycle, -> IDLE.
  - vs_start in the same cycle the 4th byte is accepted does NOT commit; the commit waits for the next vs_start.
  - ss_fall while in PENDING is ignored. A new frame can start only after the return to IDLE. The host must wait one frame (about 16.7 ms at 60 Hz) between writes.
- Latency:
  - config_out updates on the clock edge that registers vs_start, i.e. one cycle after vs reaches its asserted level.
  - config_updated is high in the same cycle config_out first shows the new value.
- Reset mid-operation: everything returns to reset values immediately; a partially collected or pending word is lost.
- Byte counter is 3 bits. It never wraps, because collection stops at the final byte.

Optional Feature:
- Macro: SPI_CFG_CHECKSUM_EN.
- When defined:
  - A frame is 5 bytes; the 5th byte is a checksum and is not shifted into shadow.
  - Checksum = XOR of the 4 data bytes.
  - On the 5th byte_valid, match -> PENDING.
  - Mismatch -> frame_error pulse, -> IDLE, shadow discarded.
  - ss_rise with fewer than 5 bytes -> frame_error.
- When undefined: 4-byte frames, no checksum, exactly as described above.

Test Plan:
- Reset: hold rst_n low, release -> config_out = 32'hBBFC0000, config_updated = 0, pending = 0.
- Normal write:
  - Stimulus: ss low, bytes 8'h40, 8'h3F, 8'h00, 8'h00, ss high.
  - Required: pending = 1 and config_out unchanged until the next vs_start.
  - Then: config_out = 32'h403F0000 and a single-cycle config_updated.
- Short frame: ss low, bytes 8'h12, 8'h34, ss high -> one frame_error pulse, pending = 0, config_out unchanged after the following vs_start.
- Edge case: ss_rise in the same cycle as the 4th byte_valid (bytes 8'hC0, 8'h00, 8'h00, 8'h01) -> no frame_error; config_out = 32'hC0000001 at the next vs_start.
- Overrun and coincidence:
  - Stimulus: a complete frame 32'hAABBCCDD, then a 5th byte 8'hEE while PENDING, and the completing byte arrives in the same cycle as vs_start.
  - Required: no commit at that vs_start; at the next vs_start config_out = 32'hAABBCCDD (the 8'hEE byte is dropped).
- Checksum (SPI_CFG_CHECKSUM_EN defined):
  - Bytes 8'h01, 8'h02, 8'h03, 8'h04, 8'h04 -> commit 32'h01020304.
  - Same data bytes with checksum 8'h05 -> frame_error, config_out unchanged.
